// File: rtl/link8b10b_pkg.sv
// Shared types and default constants for the 8b10b receive link supervisor.
package link8b10b_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    UP      = 2'd2,
    RESYNC  = 2'd3
  } link_state_t;

  localparam int DEF_ACQ_TIMEOUT   = 4096;
  localparam int DEF_RESYNC_CYCLES = 64;
  localparam int DEF_ERR_WINDOW    = 1024;
  localparam int DEF_ERR_LIMIT     = 4;

  // Value presented on the output word when nothing has been captured yet.
  localparam logic [7:0] FILL_WORD = 8'h00;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/err_window_counter.sv
// Sliding error window: a wrapping window timer plus an error counter that
// saturates at ERR_LIMIT; limitHit flags the cycle the limit is reached.
module err_window_counter
  import link8b10b_pkg::*;
#(
  parameter int ERR_WINDOW = DEF_ERR_WINDOW,
  parameter int ERR_LIMIT  = DEF_ERR_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic err_i,
  output logic limitHit
);

  localparam int TW = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
  localparam int CW = $clog2(ERR_LIMIT + 1);
  localparam logic [TW-1:0] WIN_LAST = TW'(ERR_WINDOW - 1);
  localparam logic [CW-1:0] LIMIT    = CW'(ERR_LIMIT);

  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] count_q, count_d;
  logic          wrap;

  // An error in the wrap cycle already belongs to the window that starts next.
  always_comb begin
    wrap    = (timer_q == WIN_LAST);
    timer_d = wrap ? '0 : timer_q + 1'b1;
    if (wrap) begin
      count_d = err_i ? CW'(1) : '0;
    end else if (err_i && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end else begin
      count_d = count_q;
    end
    if (clear_i) begin
      timer_d = '0;
      count_d = '0;
    end
  end

  assign limitHit = !clear_i && (count_d == LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q <= '0;
      count_q <= '0;
    end else begin
      timer_q <= timer_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rx8b10b_link_ctrl.sv
// Link supervisor: sequences rxEnable for word alignment, forces realignment
// on lock loss or excessive decode errors, and drains the receive FIFO.
module rx8b10b_link_ctrl
  import link8b10b_pkg::*;
#(
  parameter int ACQ_TIMEOUT   = DEF_ACQ_TIMEOUT,
  parameter int RESYNC_CYCLES = DEF_RESYNC_CYCLES,
  parameter int ERR_WINDOW    = DEF_ERR_WINDOW,
  parameter int ERR_LIMIT     = DEF_ERR_LIMIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        linkEnable,
  input  logic        locked,
  input  logic        decodeError,
  input  logic        dataPresent,
  input  logic [7:0]  fifoData,
  output logic        rxEnable,
  output logic        readStrobe,
  output logic        outValid,
  output logic [7:0]  outData,
  input  logic        outReady,
  output logic        linkUp,
  output logic [15:0] errorTotal
);

  localparam int AW = (ACQ_TIMEOUT > 1) ? $clog2(ACQ_TIMEOUT) : 1;
  localparam int RW = (RESYNC_CYCLES > 1) ? $clog2(RESYNC_CYCLES) : 1;
  localparam logic [AW-1:0] ACQ_LAST = AW'(ACQ_TIMEOUT - 1);
  localparam logic [RW-1:0] RES_LAST = RW'(RESYNC_CYCLES - 1);

  link_state_t   state_q, state_d;
  logic [AW-1:0] acq_timer_q;
  logic [RW-1:0] resync_timer_q;
  logic          rx_enable_q;
  logic          link_up_q;
  logic          out_valid_q;
  logic [7:0]    out_data_q;
  logic [15:0]   error_total_q;
  logic          in_up;
  logic          limit_hit;
  logic          pop;

  assign in_up = (state_q == UP);

  err_window_counter #(
    .ERR_WINDOW (ERR_WINDOW),
    .ERR_LIMIT  (ERR_LIMIT)
  ) u_err_window (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (!in_up),
    .err_i    (decodeError),
    .limitHit (limit_hit)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = ACQUIRE;
      ACQUIRE: begin
        if (locked) begin
          state_d = UP;
        end else if (acq_timer_q == ACQ_LAST) begin
          state_d = RESYNC;
        end
      end
      UP:      if (!locked || limit_hit) state_d = RESYNC;
      RESYNC:  if (resync_timer_q == RES_LAST) state_d = ACQUIRE;
      default: state_d = IDLE;
    endcase
    if (!linkEnable) begin
      state_d = IDLE;
    end
  end

  // Outside ACQUIRE and UP the FIFO is flushed; the held output word is kept.
  always_comb begin
    case (state_q)
      UP:      pop = dataPresent && (!out_valid_q || outReady);
      ACQUIRE: pop = 1'b0;
      default: pop = dataPresent;
    endcase
  end

  // No pops while reset is held, so the FIFO is not drained by a flush-in-reset.
  assign readStrobe = rst && pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      acq_timer_q    <= '0;
      resync_timer_q <= '0;
      rx_enable_q    <= 1'b0;
      link_up_q      <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= FILL_WORD;
      error_total_q  <= '0;
    end else begin
      state_q        <= state_d;
      rx_enable_q    <= (state_d == ACQUIRE) || (state_d == UP);
      link_up_q      <= (state_d == UP);
      acq_timer_q    <= ((state_q == ACQUIRE) && (state_d == ACQUIRE)) ? acq_timer_q + 1'b1 : '0;
      resync_timer_q <= ((state_q == RESYNC) && (state_d == RESYNC)) ? resync_timer_q + 1'b1 : '0;
      if (in_up && decodeError) begin
        error_total_q <= sat_inc16(error_total_q);
      end
      if (in_up && pop) begin
        out_data_q  <= fifoData;
        out_valid_q <= 1'b1;
      end else if (outReady) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign rxEnable   = rx_enable_q;
  assign linkUp     = link_up_q;
  assign outValid   = out_valid_q;
  assign outData    = out_data_q;
  assign errorTotal = error_total_q;

endmodule

// File: tb/tb_rx8b10b_link_ctrl.sv
// Directed bench for rx8b10b_link_ctrl with a cycle-level behavioural model.
module tb_rx8b10b_link_ctrl;

  localparam int P_ACQ = 16;
  localparam int P_RES = 64;
  localparam int P_WIN = 32;
  localparam int P_LIM = 4;
  localparam int S_IDLE = 0;
  localparam int S_ACQ  = 1;
  localparam int S_UP   = 2;
  localparam int S_RES  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        linkEnable = 1'b0;
  logic        locked = 1'b0;
  logic        decodeError = 1'b0;
  logic        dataPresent = 1'b0;
  logic [7:0]  fifoData = 8'h00;
  logic        outReady = 1'b0;
  logic        rxEnable;
  logic        readStrobe;
  logic        outValid;
  logic [7:0]  outData;
  logic        linkUp;
  logic [15:0] errorTotal;

  rx8b10b_link_ctrl #(
    .ACQ_TIMEOUT   (P_ACQ),
    .RESYNC_CYCLES (P_RES),
    .ERR_WINDOW    (P_WIN),
    .ERR_LIMIT     (P_LIM)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .linkEnable  (linkEnable),
    .locked      (locked),
    .decodeError (decodeError),
    .dataPresent (dataPresent),
    .fifoData    (fifoData),
    .rxEnable    (rxEnable),
    .readStrobe  (readStrobe),
    .outValid    (outValid),
    .outData     (outData),
    .outReady    (outReady),
    .linkUp      (linkUp),
    .errorTotal  (errorTotal)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   run = 1'b0;
  logic pop_seen = 1'b0;
  int   strobe_count = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] delivered[$];
  int   err_k [19] = '{5, 10, 20, 37, 42, 52, 69, 74, 84, 110, 115, 120, 127,
                       130, 135, 165, 167, 169, 171};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_err(input int k);
    foreach (err_k[i]) if (err_k[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- behavioural model ----------------
  int         m_st = S_IDLE;
  int         m_age = 0;
  int         m_win_id = 0;
  int         m_win_errs = 0;
  int         m_total = 0;
  int         m_nxt;
  int         m_id;
  logic       m_pop;
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;

  function automatic logic m_strobe();
    if (m_st == S_UP)  return dataPresent && (!m_valid || outReady);
    if (m_st == S_ACQ) return 1'b0;
    return dataPresent;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_st = S_IDLE; m_age = 0; m_win_id = 0; m_win_errs = 0;
      m_total = 0; m_valid = 1'b0; m_data = 8'h00;
    end else begin
      m_pop = m_strobe();
      m_nxt = m_st;
      case (m_st)
        S_IDLE: m_nxt = S_ACQ;
        S_ACQ:  m_nxt = locked ? S_UP : ((m_age == P_ACQ - 1) ? S_RES : S_ACQ);
        S_UP: begin
          if (decodeError) begin
            // UP cycle k belongs to window (k+1)/P_WIN
            m_id = (m_age + 1) / P_WIN;
            if (m_id != m_win_id) begin
              m_win_id = m_id;
              m_win_errs = 0;
            end
            m_win_errs++;
            if (m_total < 65535) m_total++;
          end
          m_nxt = (!locked || m_win_errs >= P_LIM) ? S_RES : S_UP;
        end
        default: m_nxt = (m_age == P_RES - 1) ? S_ACQ : S_RES;
      endcase
      if (!linkEnable) m_nxt = S_IDLE;
      if (m_st == S_UP && m_pop) begin
        m_data = fifoData;
        m_valid = 1'b1;
      end else if (outReady) begin
        m_valid = 1'b0;
      end
      if (m_nxt != m_st) begin
        m_age = 0; m_win_id = 0; m_win_errs = 0;
      end else begin
        m_age++;
      end
      m_st = m_nxt;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    pop_seen = readStrobe;
    if (rst && readStrobe) strobe_count++;
    if (rst && outValid && outReady) begin
      delivered.push_back(outData);
      $display("word delivered: %02h at cycle %0d", outData, cyc);
    end
    if (run && rst) begin
      check("rxEnable",   32'(rxEnable),   32'((m_st == S_ACQ) || (m_st == S_UP)));
      check("linkUp",     32'(linkUp),     32'(m_st == S_UP));
      check("outValid",   32'(outValid),   32'(m_valid));
      check("outData",    32'(outData),    32'(m_data));
      check("errorTotal", 32'(errorTotal), 32'(m_total));
      check("readStrobe", 32'(readStrobe), 32'(m_strobe()));
      if (m_st == S_UP && outValid && !outReady)
        check("hold_no_pop", 32'(readStrobe), 32'(0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic fifo_drive();
    dataPresent = (fifo_q.size() != 0);
    fifoData = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    fifo_drive();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (pop_seen && fifo_q.size() != 0) void'(fifo_q.pop_front());
    fifo_drive();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_rxEnable"},   32'(rxEnable),   32'(0));
    check({tag, "_linkUp"},     32'(linkUp),     32'(0));
    check({tag, "_outValid"},   32'(outValid),   32'(0));
    check({tag, "_outData"},    32'(outData),    32'(0));
    check({tag, "_errorTotal"}, 32'(errorTotal), 32'(0));
    check({tag, "_readStrobe"}, 32'(readStrobe), 32'(0));
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    rst = 1'b1;
    run = 1'b1;
    cyc = 0;

    // Timeout: no lock, ACQUIRE 1..16, RESYNC 17..80, ACQUIRE again at 81
    linkEnable = 1'b1;
    tick();
    check("acq_rxen_c1", 32'(rxEnable), 32'(1));
    while (cyc < 16) tick();
    check("timeout_rxen_c16", 32'(rxEnable), 32'(1));
    tick();
    check("timeout_rxen_c17", 32'(rxEnable), 32'(0));
    while (cyc < 80) tick();
    check("resync_rxen_c80", 32'(rxEnable), 32'(0));
    tick();
    check("reacq_rxen_c81", 32'(rxEnable), 32'(1));

    // Acquire: lock at 91 -> linkUp at 92
    while (cyc < 91) tick();
    locked = 1'b1;
    check("acq_linkup_c91", 32'(linkUp), 32'(0));
    tick();
    check("acq_linkup_c92", 32'(linkUp), 32'(1));

    // Error window: 3 per window, a wrap-cycle error, then 4 in one window
    for (int k = 0; k < 172; k++) begin
      if (k == 32 || k == 64 || k == 96)
        check("win_errtotal", 32'(errorTotal), 32'(3 * (k / 32)));
      if (k == 160) begin
        check("wrap_errtotal", 32'(errorTotal), 32'(15));
        check("wrap_still_up", 32'(linkUp), 32'(1));
      end
      decodeError = is_err(k);
      tick();
    end
    decodeError = 1'b0;
    check("limit_rxen_off", 32'(rxEnable), 32'(0));
    check("limit_linkup_off", 32'(linkUp), 32'(0));
    check("limit_errtotal", 32'(errorTotal), 32'(19));

    // Flush in RESYNC: three words popped, none presented
    push(8'hC1); push(8'hC2); push(8'hC3);
    strobe_count = 0;
    repeat (5) tick();
    check("flush_strobes", 32'(strobe_count), 32'(3));
    check("flush_outvalid", 32'(outValid), 32'(0));
    check("flush_fifo_empty", 32'(fifo_q.size()), 32'(0));
    while (cyc < 328) tick();
    check("reacq_linkup_c328", 32'(linkUp), 32'(0));
    tick();
    check("reacq_linkup_c329", 32'(linkUp), 32'(1));

    // Drain with back-pressure
    delivered.delete();
    for (int i = 0; i < 5; i++) push(8'hA1 + 8'(i));
    for (int i = 0; i < 14; i++) begin
      outReady = (i % 2 == 0);
      tick();
    end
    check("drain_count", 32'(delivered.size()), 32'(5));
    for (int i = 0; i < 5 && i < delivered.size(); i++)
      check("drain_order", 32'(delivered[i]), 32'(8'hA1 + 8'(i)));

    // Throughput: one word per cycle with outReady held high
    outReady = 1'b1;
    delivered.delete();
    for (int i = 0; i < 4; i++) push(8'hB1 + 8'(i));
    repeat (5) tick();
    check("stream_count", 32'(delivered.size()), 32'(4));
    if (delivered.size() == 4) check("stream_last", 32'(delivered[3]), 32'(8'hB4));

    // IDLE flush keeps a held word until accepted
    outReady = 1'b0;
    delivered.delete();
    push(8'hD1);
    tick();
    linkEnable = 1'b0;
    tick();
    push(8'hE1); push(8'hE2);
    strobe_count = 0;
    repeat (3) tick();
    check("idle_flush_strobes", 32'(strobe_count), 32'(2));
    check("idle_held_valid", 32'(outValid), 32'(1));
    check("idle_held_data", 32'(outData), 32'(8'hD1));
    outReady = 1'b1;
    tick();
    check("idle_accept_valid", 32'(outValid), 32'(0));
    check("idle_accept_count", 32'(delivered.size()), 32'(1));

    // Re-enable, then async reset while a word is held
    linkEnable = 1'b1;
    outReady = 1'b0;
    repeat (2) tick();
    check("reenable_linkup", 32'(linkUp), 32'(1));
    check("errtotal_kept", 32'(errorTotal), 32'(19));
    push(8'hF1);
    repeat (2) tick();
    check("pre_reset_valid", 32'(outValid), 32'(1));
    #3 rst = 1'b0;
    #1;
    run = 1'b0;
    reset_checks("async_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout, required completion at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
